// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// The lookup is combinational on the IF-stage PC. ID-stage resolutions update
// the table on the clock edge. Branch and mispredict performance counters are
// kept alongside the table.
module branch_predictor #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int CNT_W   = 32
) (
   input  logic              clk_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] next_pc_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_pred_taken_i,
   input  logic [ADDR_W-1:0] upd_pred_target_i,
   input  logic              flush_i,
   output logic [CNT_W-1:0]  branch_cnt_o,
   output logic [CNT_W-1:0]  mispred_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   // Newly allocated entries start weakly taken: MSB set, all other bits clear.
   localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [ADDR_W-1:0]  target_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];

   logic [CNT_W-1:0]   branch_cnt_q;
   logic [CNT_W-1:0]   mispred_cnt_q;

   logic [IDX_W-1:0]   lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;
   logic               lk_taken;

   logic [IDX_W-1:0]   upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               upd_hit;
   logic               upd_mispred;

   // The low two PC bits never select an entry.
   logic               upd_pc_lsb_unused;
   assign upd_pc_lsb_unused = ^upd_pc_i[1:0];

   // Combinational lookup of the fetch PC against the current table state.
   always_comb begin
      lk_idx    = pc_i[IDX_W+1:2];
      lk_tag    = pc_i[ADDR_W-1:IDX_W+2];
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
      pred_taken_o = lk_taken;
      next_pc_o    = lk_taken ? target_q[lk_idx] : pc_i + ADDR_W'(4);
   end

   // Decode the resolved branch: entry hit and whether the prediction was wrong.
   always_comb begin
      upd_idx     = upd_pc_i[IDX_W+1:2];
      upd_tag     = upd_pc_i[ADDR_W-1:IDX_W+2];
      upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      upd_mispred = (upd_pred_taken_i != upd_taken_i) ||
                    (upd_taken_i && (upd_pred_target_i != upd_target_i));
   end

   // Table state: flush invalidates everything and discards any concurrent update.
   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= '0;
         end
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (upd_valid_i) begin
         if (upd_hit) begin
            if (upd_taken_i) begin
               target_q[upd_idx] <= upd_target_i;
               if (ctr_q[upd_idx] != '1)
                  ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
            end else if (ctr_q[upd_idx] != '0) begin
               ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
            end
         end else if (upd_taken_i) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target_i;
            ctr_q[upd_idx]    <= CTR_WEAK_T;
         end
      end
   end

   // Performance counters count every resolution, flush or not, and wrap.
   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (upd_valid_i) begin
         branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         if (upd_mispred)
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor: each row is one cycle of inputs plus
// the outputs expected before that cycle's edge. Hand-written sequences cover
// asynchronous reset in mid-cycle.
module tb_branch_predictor;

   logic        clk_i = 1'b0;
   logic        start_i;
   logic [31:0] pc_i;
   logic        pred_taken_o;
   logic [31:0] next_pc_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [31:0] upd_pred_target_i;
   logic        flush_i;
   logic [3:0]  branch_cnt_o;
   logic [3:0]  mispred_cnt_o;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(
      .ADDR_W (32),
      .ENTRIES(64),
      .CTR_W  (2),
      .CNT_W  (4)
   ) dut (
      .clk_i            (clk_i),
      .start_i          (start_i),
      .pc_i             (pc_i),
      .pred_taken_o     (pred_taken_o),
      .next_pc_o        (next_pc_o),
      .upd_valid_i      (upd_valid_i),
      .upd_pc_i         (upd_pc_i),
      .upd_taken_i      (upd_taken_i),
      .upd_target_i     (upd_target_i),
      .upd_pred_taken_i (upd_pred_taken_i),
      .upd_pred_target_i(upd_pred_target_i),
      .flush_i          (flush_i),
      .branch_cnt_o     (branch_cnt_o),
      .mispred_cnt_o    (mispred_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic        fl;
      logic        e_pred;
      logic [31:0] e_next;
      int          e_bcnt;
      int          e_mcnt;
   } vec_t;

   typedef struct {
      logic        pred;
      logic [31:0] next;
      logic [3:0]  bcnt;
      logic [3:0]  mcnt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t mk(logic [31:0] pc, logic uv, logic [31:0] upc, logic ut,
                               logic [31:0] utgt, logic upt, logic [31:0] uptgt, logic fl,
                               logic e_pred, logic [31:0] e_next, int e_bcnt, int e_mcnt);
      vec_t v;
      v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
      v.upt = upt; v.uptgt = uptgt; v.fl = fl;
      v.e_pred = e_pred; v.e_next = e_next; v.e_bcnt = e_bcnt; v.e_mcnt = e_mcnt;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_outputs(input int idx, input exp_t e);
      cmp("pred_taken", idx, {31'd0, pred_taken_o}, {31'd0, e.pred});
      cmp("next_pc", idx, next_pc_o, e.next);
      cmp("branch_cnt", idx, {28'd0, branch_cnt_o}, {28'd0, e.bcnt});
      cmp("mispred_cnt", idx, {28'd0, mispred_cnt_o}, {28'd0, e.mcnt});
   endtask

   task automatic idle_inputs();
      upd_valid_i       = 1'b0;
      upd_pc_i          = '0;
      upd_taken_i       = 1'b0;
      upd_target_i      = '0;
      upd_pred_taken_i  = 1'b0;
      upd_pred_target_i = '0;
      flush_i           = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      // pc, uv, upc, ut, utgt, upt, uptgt, fl | pred, next, bcnt, mcnt
      vecs.push_back(mk(32'h10, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h14, 0, 0));
      vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h40,  0, 32'h14,  0, 0, 32'h14, 0, 0));
      vecs.push_back(mk(32'h10, 1, 32'h10, 1, 32'h40,  1, 32'h40,  0, 1, 32'h40, 1, 1));
      vecs.push_back(mk(32'h10, 1, 32'h10, 0, 32'h40,  1, 32'h40,  0, 1, 32'h40, 2, 1));
      vecs.push_back(mk(32'h10, 1, 32'h10, 0, 32'h40,  1, 32'h40,  0, 1, 32'h40, 3, 2));
      vecs.push_back(mk(32'h10, 1, 32'h10, 0, 32'h40,  0, 32'h14,  0, 0, 32'h14, 4, 3));
      vecs.push_back(mk(32'h10, 1, 32'h10, 0, 32'h40,  0, 32'h14,  0, 0, 32'h14, 5, 3));
      vecs.push_back(mk(32'h10, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h14, 6, 3));
      vecs.push_back(mk(32'h110,0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h114,6, 3));
      vecs.push_back(mk(32'h110,1, 32'h110,1, 32'h200, 0, 32'h114, 0, 0, 32'h114,6, 3));
      vecs.push_back(mk(32'h110,0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 32'h200,7, 4));
      vecs.push_back(mk(32'h10, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h14, 7, 4));
      vecs.push_back(mk(32'h20, 1, 32'h20, 1, 32'h300, 0, 32'h24,  1, 0, 32'h24, 7, 4));
      vecs.push_back(mk(32'h20, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h24, 8, 5));
      vecs.push_back(mk(32'h110,0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h114,8, 5));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h80,  1, 32'h80,  0, 0, 32'h34, 8, 5));
      vecs.push_back(mk(32'h30, 1, 32'h30, 0, 32'h80,  1, 32'h80,  0, 1, 32'h80, 9, 5));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h80,  1, 32'h84,  0, 0, 32'h34, 10,6));
      vecs.push_back(mk(32'h30, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 32'h80, 11,7));
      vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 11,7));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h90,  1, 32'h80,  0, 1, 32'h80, 11,7));
      vecs.push_back(mk(32'h30, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 32'h90, 12,8));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h90,  1, 32'h90,  0, 1, 32'h90, 12,8));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h90,  1, 32'h90,  0, 1, 32'h90, 13,8));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h90,  1, 32'h90,  0, 1, 32'h90, 14,8));
      vecs.push_back(mk(32'h30, 1, 32'h30, 1, 32'h90,  1, 32'h90,  0, 1, 32'h90, 15,8));
      vecs.push_back(mk(32'h30, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 1, 32'h90, 0, 8));
      vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h50,  0, 32'h44,  0, 0, 32'h44, 0, 8));
      vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 32'h44, 1, 8));

      // Reset and check the reset state while reset is held.
      start_i = 1'b0;
      pc_i    = 32'h10;
      idle_inputs();
      repeat (2) @(posedge clk_i);
      #2;
      e.pred = 1'b0; e.next = 32'h14; e.bcnt = 4'd0; e.mcnt = 4'd0;
      check_outputs(-1, e);
      @(negedge clk_i);
      start_i = 1'b1;

      // Table rows: drive after the edge, push the expectation, compare before the next edge.
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk_i);
         #1;
         pc_i              = vecs[i].pc;
         upd_valid_i       = vecs[i].uv;
         upd_pc_i          = vecs[i].upc;
         upd_taken_i       = vecs[i].ut;
         upd_target_i      = vecs[i].utgt;
         upd_pred_taken_i  = vecs[i].upt;
         upd_pred_target_i = vecs[i].uptgt;
         flush_i           = vecs[i].fl;
         e.pred = vecs[i].e_pred;
         e.next = vecs[i].e_next;
         e.bcnt = 4'(vecs[i].e_bcnt);
         e.mcnt = 4'(vecs[i].e_mcnt);
         sb.push_back(e);
         @(negedge clk_i);
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty row=%0d actual=0 expected=1", i);
         end else begin
            check_outputs(i, sb.pop_front());
         end
      end

      // Mid-cycle asynchronous reset with a live entry at 0x30 (ctr 11, target 0x90).
      @(posedge clk_i);
      #1;
      idle_inputs();
      pc_i = 32'h30;
      #2;
      e.pred = 1'b1; e.next = 32'h90; e.bcnt = 4'd1; e.mcnt = 4'd8;
      check_outputs(100, e);
      start_i = 1'b0;
      #1;
      e.pred = 1'b0; e.next = 32'h34; e.bcnt = 4'd0; e.mcnt = 4'd0;
      check_outputs(101, e);

      // Updates offered while reset is held must be ignored.
      upd_valid_i       = 1'b1;
      upd_pc_i          = 32'h30;
      upd_taken_i       = 1'b1;
      upd_target_i      = 32'h90;
      upd_pred_taken_i  = 1'b0;
      upd_pred_target_i = 32'h34;
      repeat (2) @(posedge clk_i);
      #1;
      check_outputs(102, e);
      @(negedge clk_i);
      idle_inputs();
      start_i = 1'b1;
      #1;
      check_outputs(103, e);
      @(posedge clk_i);
      #1;
      check_outputs(104, e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, for the 5-stage RISC-V pipeline.
- Sits beside PC in IF. Each cycle it looks up the current PC combinationally and supplies the predicted next PC.
- ID stage resolves beq and sends an update one or more cycles later; a misprediction still flushes IF/ID as today.
- Also keeps branch and mispredict performance counters.

Parameters:
ADDR_W, 32, PC/target width in bits
ENTRIES, 64, BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width in bits, >=1
CNT_W, 32, performance counter width in bits

Ports:
clk_i  input  1  clock, rising edge
start_i  input  1  asynchronous active-low reset (0 = reset)
pc_i  input  ADDR_W  IF-stage PC being fetched
pred_taken_o  output  1  lookup hit and counter predicts taken
next_pc_o  output  ADDR_W  predicted next fetch PC
upd_valid_i  input  1  ID reports a resolved branch this cycle
upd_pc_i  input  ADDR_W  PC of the resolved branch
upd_taken_i  input  1  actual outcome
upd_target_i  input  ADDR_W  actual taken target
upd_pred_taken_i  input  1  prediction that was used for this branch
upd_pred_target_i  input  ADDR_W  next_pc that was used for this branch
flush_i  input  1  synchronous invalidate of all entries
branch_cnt_o  output  CNT_W  count of resolved branches
mispred_cnt_o  output  CNT_W  count of mispredictions

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid, tag, target[ADDR_W], ctr[CTR_W], all held in flops (no SRAM).
- Lookup is purely combinational from current state:
  - hit = valid[idx] && tag[idx] == tag(pc_i)
  - pred_taken_o = hit && ctr[idx][CTR_W-1]
  - next_pc_o = pred_taken_o ? target[idx] : pc_i + 4, truncated to ADDR_W (wraps).
- Update, on the rising edge with upd_valid_i=1 and flush_i=0:
  - Hit on upd_pc_i, taken: ctr saturating +1 (max 2^CTR_W-1); target <= upd_target_i.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate or replace the entry. valid=1, tag, target, ctr = weakly taken (MSB=1, other bits 0; 2'b10 for CTR_W=2).
  - Miss, not taken: no state change.
- No bypass: a same-cycle lookup and update to the same index returns the pre-update value. The new value is visible the next cycle.
- flush_i=1 clears every valid bit on the next edge. Counters, tags and targets are don't-care. A simultaneous update is discarded.
- Performance counters, updated on every edge with upd_valid_i=1, independent of flush_i:
  - branch_cnt_o += 1.
  - mispred_cnt_o += 1 if upd_pred_taken_i != upd_taken_i, or if (upd_taken_i && upd_pred_target_i != upd_target_i).
  - Both wrap modulo 2^CNT_W.
- Reset (start_i=0), asynchronous and taking effect immediately, including mid-operation:
  - All valid bits = 0, all ctr = 0, both perf counters = 0; tags and targets also cleared to 0.
  - Outputs during and after reset: pred_taken_o=0, next_pc_o=pc_i+4, branch_cnt_o=0, mispred_cnt_o=0.
  - Updates are ignored while start_i=0.
- Latency: prediction 0 cycles (combinational); update visible 1 cycle after the update edge.

Test Plan:
- Reset, then pc_i=0x10 -> pred_taken_o=0, next_pc_o=0x14; both counters 0.
- Update pc=0x10, taken, target=0x40, pred_taken=0 -> next cycle pc_i=0x10 gives pred_taken_o=1, next_pc_o=0x40; branch_cnt_o=1, mispred_cnt_o=1.
- Two more updates of 0x10: taken (ctr 10->11), then not taken (ctr 11->10) -> still predicts taken. Two further not-taken updates (10->01->00), then a third (stays 00) -> pred_taken_o=0, next_pc_o=0x14.
- Alias, ENTRIES=64: 0x110 shares index 4 with 0x10 -> lookup misses. Taken update 0x110 with target 0x200 -> 0x110 predicts 0x200; 0x10 now misses (next_pc_o=0x14).
- flush_i=1 on the same edge as a taken update of 0x20 -> all lookups miss afterwards, including 0x20; branch_cnt_o still increments.
- Mispredict accounting: three updates, (pred T, actual T, same target), (pred T, actual N), (pred T, actual T, target 0x80 vs predicted 0x84) -> branch_cnt_o=3, mispred_cnt_o=2. Then drop start_i mid-cycle -> all outputs return to reset values immediately.
- Same-cycle lookup and update to the same index -> lookup returns the old value; the new value appears next cycle.
- Counter wrap with CNT_W=4: 16 updates -> branch_cnt_o=0.
